ex_mem_pipe_reg: RTL and testbench

- Parametrised EX->MEM pipeline register. It is the successor to the fixed 32-bit freeze-only stage register.
- Carries the EX result bundle: control enables, PC, ALU result, store value and destination register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so backpressure from MEM never drops a result.
- Adds a synchronous flush, and keeps a legacy freeze input.

---
 rtl/ex_mem_pipe_reg.sv | 132 +++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// The main entry drives the MEM-side outputs. The skid entry holds one overflow bundle.
// Also provides a synchronous flush and a legacy freeze input.
// Optional feature macro: EXMEM_STALL_CNT_EN adds a saturating stall_cnt output.
module ex_mem_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   alu_result_in,
  input  logic [XLEN-1:0]   st_val_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   alu_result,
  output logic [XLEN-1:0]   st_val,
  output logic [DEST_W-1:0] dest
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // One bundle packed as {wb, mem_r, mem_w, pc, alu_result, st_val, dest}
  localparam int BW = 3 + 3 * XLEN + DEST_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_main;
  logic [BW-1:0]   r_skid;

  logic [BW-1:0]   w_in_bundle;
  logic            w_in_fire;
  logic            w_eff_ready;
  logic            w_out_fire;

  assign w_in_bundle = {wb_en_in, mem_r_en_in, mem_w_en_in,
                        pc_in, alu_result_in, st_val_in, dest_in};

  // Handshake status comes only from the state register, so in_ready has no
  // combinational dependency on out_ready.
  assign in_ready    = (r_state != FULL);
  assign out_valid   = (r_state != EMPTY);
  assign w_in_fire   = in_valid & in_ready;
  assign w_eff_ready = out_ready & ~freeze;
  assign w_out_fire  = out_valid & w_eff_ready;

  // Occupancy FSM plus main/skid data capture; flush only empties, never clears data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main  <= w_in_bundle;
            r_state <= HALF;
          end
        end
        HALF: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= w_in_bundle;
          end else if (w_in_fire) begin
            r_skid  <= w_in_bundle;
            r_state <= FULL;
          end else if (w_out_fire) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_state <= HALF;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Control enables are gated so a bubble never looks like a live instruction
  assign wb_en      = r_main[BW-1] & out_valid;
  assign mem_r_en   = r_main[BW-2] & out_valid;
  assign mem_w_en   = r_main[BW-3] & out_valid;
  assign pc         = r_main[3*XLEN+DEST_W-1 -: XLEN];
  assign alu_result = r_main[2*XLEN+DEST_W-1 -: XLEN];
  assign st_val     = r_main[XLEN+DEST_W-1 -: XLEN];
  assign dest       = r_main[DEST_W-1:0];

`ifdef EXMEM_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Count cycles where a valid head is blocked; saturates, survives flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !w_eff_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  // CNT_W only sizes the optional counter; keep it referenced in the base build
  logic [CNT_W-1:0] w_unused_cnt_w;
  assign w_unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed scenarios plus random traffic
// compared against a queue-based reference model of a 2-deep FIFO stage.
module tb_ex_mem_pipe_reg;

  localparam int XLEN   = 32;
  localparam int DEST_W = 5;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic              wb;
    logic              mr;
    logic              mw;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   st;
    logic [DEST_W-1:0] dest;
  } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic freeze = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  bundle_t drv = '0;

  logic              in_ready, out_valid;
  logic              wb_en, mem_r_en, mem_w_en;
  logic [XLEN-1:0]   pc, alu_result, st_val;
  logic [DEST_W-1:0] dest;
  logic [CNT_W-1:0]  stall_obs;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.XLEN(XLEN), .DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(drv.wb), .mem_r_en_in(drv.mr), .mem_w_en_in(drv.mw),
    .pc_in(drv.pc), .alu_result_in(drv.alu), .st_val_in(drv.st), .dest_in(drv.dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .pc(pc), .alu_result(alu_result), .st_val(st_val), .dest(dest)
`ifdef EXMEM_STALL_CNT_EN
    , .stall_cnt(stall_obs)
`endif
  );

`ifndef EXMEM_STALL_CNT_EN
  assign stall_obs = '0;
`endif

  // Reference model: a FIFO of at most two bundles plus a stall counter
  bundle_t q[$];
  int      m_stall = 0;
  int      n_cmp = 0;
  int      n_err = 0;

  function automatic bundle_t rand_b();
    bundle_t b;
    b.wb   = 1'($urandom);
    b.mr   = 1'($urandom);
    b.mw   = 1'($urandom);
    b.pc   = $urandom;
    b.alu  = $urandom;
    b.st   = $urandom;
    b.dest = DEST_W'($urandom);
    return b;
  endfunction

  // Observed: {out_valid, in_ready, ctrl, data-if-valid, stall}
  function automatic logic [127:0] dut_vec();
    logic [100:0] d;
    d = out_valid ? {pc, alu_result, st_val, dest} : '0;
    return {18'd0, out_valid, in_ready, wb_en, mem_r_en, mem_w_en, d, stall_obs};
  endfunction

  function automatic logic [127:0] model_vec();
    logic [100:0] d;
    logic [2:0]   c;
    logic [3:0]   s;
    d = '0;
    c = '0;
    if (q.size() > 0) begin
      d = {q[0].pc, q[0].alu, q[0].st, q[0].dest};
      c = {q[0].wb, q[0].mr, q[0].mw};
    end
`ifdef EXMEM_STALL_CNT_EN
    s = 4'(m_stall);
`else
    s = 4'd0;
`endif
    return {18'd0, q.size() > 0, q.size() < 2, c, d, s};
  endfunction

  // Apply one rising edge to the model using the currently driven inputs
  task automatic model_edge();
    bit in_fire, out_fire;
    in_fire  = in_valid && (q.size() < 2);
    out_fire = (q.size() > 0) && out_ready && !freeze;
    if (q.size() > 0 && !(out_ready && !freeze) && m_stall < (1 << CNT_W) - 1)
      m_stall++;
    if (flush) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(drv);
    end
  endtask

  // One clock: model follows the edge, DUT sampled afterwards at the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bundle_t b;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, wb_en, mem_r_en, mem_w_en, pc, alu_result, st_val, dest, stall_obs} !== {2'b01, 3'b0, 101'd0, 4'd0}) begin
      n_err++;
      $display("FAIL reset_state got v=%b r=%b pc=%h alu=%h dest=%h exp v=0 r=1 all zero",
               out_valid, in_ready, pc, alu_result, dest);
    end else $display("reset_state ok");
    rst = 1'b1;
    q.delete();
    m_stall = 0;
    b = '0;
    b.pc = 32'h100; b.alu = 32'hDEAD; b.dest = 5'd7; b.wb = 1'b1;
    drv = b; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, pc, alu_result, dest, wb_en} !== {1'b1, 32'h100, 32'hDEAD, 5'd7, 1'b1}) begin
      n_err++;
      $display("FAIL first_accept got v=%b pc=%h alu=%h dest=%0d wb=%b exp v=1 pc=100 alu=dead dest=7 wb=1",
               out_valid, pc, alu_result, dest, wb_en);
    end else $display("first_accept ok pc=%h", pc);
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL first_drain got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drv = rand_b();
      drv.pc = 32'(4 * k);
      in_valid = 1'b1;
      step();
      n_cmp++;
      if (dut_vec() !== model_vec() || !out_valid || pc !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL stream[%0d] got v=%b pc=%h exp v=1 pc=%h", k, out_valid, pc, 32'(4 * k));
      end else $display("stream[%0d] ok pc=%h", k, pc);
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL stream_end got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_pc[3];
    exp_pc = '{32'h10, 32'h14, 32'h18};
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drv = rand_b();
      drv.pc = exp_pc[k];
      in_valid = 1'b1;
      step();
      n_cmp++;
      if (dut_vec() !== model_vec() || pc !== 32'h10) begin
        n_err++;
        $display("FAIL fill[%0d] got %h exp %h", k, dut_vec(), model_vec());
      end else $display("fill[%0d] ok head=%h in_ready=%b", k, pc, in_ready);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_in_ready got %b exp 0", in_ready);
    end
    // 0x18 is still offered by the source while the stage drains
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (!out_valid || pc !== exp_pc[k] || dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL drain[%0d] got v=%b pc=%h exp v=1 pc=%h", k, out_valid, pc, exp_pc[k]);
      end else $display("drain[%0d] ok pc=%h", k, pc);
      step();
      if (q.size() > 0 && q[q.size()-1].pc == 32'h18) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (dut_vec() !== model_vec() || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_valid = 1'b1;
    drv = rand_b(); drv.mw = 1'b1; drv.wb = 1'b1;
    step();
    drv = rand_b();
    step();
    drv = rand_b(); drv.pc = 32'hBAD0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, wb_en, mem_w_en, in_ready} !== 4'b0001 || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL flush_full got v=%b wb=%b mw=%b r=%b exp v=0 wb=0 mw=0 r=1",
               out_valid, wb_en, mem_w_en, in_ready);
    end else $display("flush_full ok");
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL flush_no_leak[%0d] got v=%b pc=%h exp v=0", k, out_valid, pc);
      end
    end
  endtask

  task automatic test_freeze();
    bundle_t head;
    int      cnt0;
    head = rand_b();
    drv = head; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    freeze = 1'b1;
    cnt0 = m_stall;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (!out_valid || {pc, alu_result, st_val, dest} !== {head.pc, head.alu, head.st, head.dest}
          || dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL freeze_hold[%0d] got v=%b pc=%h exp v=1 pc=%h", k, out_valid, pc, head.pc);
      end else $display("freeze_hold[%0d] ok pc=%h stall=%0d", k, pc, stall_obs);
    end
`ifdef EXMEM_STALL_CNT_EN
    n_cmp++;
    if (32'(stall_obs) !== ((cnt0 + 5 > 15) ? 15 : cnt0 + 5)) begin
      n_err++;
      $display("FAIL freeze_stall_cnt got %0d exp %0d", stall_obs, cnt0 + 5);
    end
`endif
    // In HALF under freeze exactly one more bundle lands in skid
    drv = rand_b(); in_valid = 1'b1;
    step();
    step();
    n_cmp++;
    if (in_ready !== 1'b0 || pc !== head.pc || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL freeze_fill got r=%b pc=%h exp r=0 pc=%h", in_ready, pc, head.pc);
    end
    in_valid = 1'b0;
    freeze = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (dut_vec() !== model_vec() || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL freeze_release got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_async_reset();
    bundle_t b;
    out_ready = 1'b0;
    in_valid = 1'b1;
    drv = rand_b(); step();
    drv = rand_b(); step();
    in_valid = 1'b0;
    @(posedge clk);
    model_edge();
    #2 rst = 1'b0;
    #1;
    q.delete();
    m_stall = 0;
    n_cmp++;
    if ({out_valid, in_ready, wb_en, mem_r_en, mem_w_en, pc, alu_result, st_val, dest, stall_obs} !== {2'b01, 3'b0, 101'd0, 4'd0}) begin
      n_err++;
      $display("FAIL async_reset got v=%b r=%b pc=%h alu=%h exp v=0 r=1 all zero",
               out_valid, in_ready, pc, alu_result);
    end else $display("async_reset ok");
    @(negedge clk);
    rst = 1'b1;
    b = rand_b();
    drv = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (pc !== b.pc || !out_valid || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL post_reset_accept got pc=%h v=%b exp pc=%h v=1", pc, out_valid, b.pc);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL no_stale_skid got v=%b pc=%h exp v=0", out_valid, pc);
    end else $display("no_stale_skid ok");
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drv       = rand_b();
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 65);
      freeze    = ($urandom_range(0, 99) < 15);
      flush     = ($urandom_range(0, 99) < 5);
      if (q.size() > 0 && out_ready && !freeze)
        $display("random[%0d] out pc=%h", k, q[0].pc);
      step();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL random[%0d] got %h exp %h", k, dut_vec(), model_vec());
      end
    end
    flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_drain();
    test_flush_full();
    test_freeze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
